fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
REQ-002 Parameter AW, default 32: address and PC width in bits.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 Parameter ADDR_STEP, default 1: PC increment per fetch (word-addressed instruction memory).
REQ-005 clk  input  1  rising-edge clock, shared with the instruction memory.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 im_addr  output  AW  address driven to the instruction memory.
REQ-008 im_en  output  1  high when im_addr carries a live request.
REQ-009 im_instr  input  32  instruction-memory read data; registered, valid one cycle after im_addr.
REQ-010 redirect  input  1  load a new PC and squash the in-flight fetch.
REQ-011 redirect_addr  input  AW  target PC for redirect.
REQ-012 halt  input  1  stop issuing new fetches.
REQ-013 instr  output  32  fetched instruction; combinational pass-through of im_instr.
REQ-014 instr_pc  output  AW  address of instr.
REQ-015 instr_valid  output  1  instr/instr_pc are valid.
REQ-016 instr_ready  input  1  consumer accepts instr this cycle.

Function
REQ-017 State register SHALL be {IDLE, RUN, HALT}; registers: pc (next issue address), req_pc, req_v.
REQ-018 IDLE: im_en=0, instr_valid=0; the first rising edge after rst_n deasserts SHALL move to RUN.
REQ-019 instr_valid SHALL equal req_v, and instr_pc SHALL equal req_pc.
REQ-020 RUN, no redirect, no hold: im_addr=pc, im_en=1; at the edge req_pc<=pc, req_v<=1, pc<=pc+ADDR_STEP.
REQ-021 Hold (req_v=1 and instr_ready=0): im_addr=req_pc, im_en=1 (re-read the same word); pc, req_pc and req_v SHALL be unchanged.
REQ-022 Latency SHALL be one cycle from issue to instr_valid; sustained throughput SHALL be one instruction per cycle while instr_ready=1.
REQ-023 pc+ADDR_STEP SHALL wrap modulo 2^AW (for example, all-ones+1 -> 0).
REQ-024 redirect=1 in any state except IDLE: im_en=0; at the edge pc<=redirect_addr and req_v<=0. Redirect SHALL take priority over hold.
REQ-025 halt=1 in RUN without redirect: no new issue; an in-flight request SHALL complete its handshake; the state SHALL move to HALT once req_v=0 or the request is accepted.
REQ-026 HALT: im_en=0 and pc held; redirect with halt=0 SHALL move to RUN; redirect with halt=1 SHALL stay in HALT with pc loaded.
REQ-027 Simultaneous redirect and halt in RUN: pc<=redirect_addr, req_v<=0, next state HALT.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, pc=RESET_PC, req_pc=0, req_v=0, im_en=0, instr_valid=0.
REQ-029 Reset mid-operation SHALL discard any in-flight fetch without producing instr_valid.

Configuration
REQ-030 Macro FETCH_CTRL_PERF_EN, when defined, SHALL add outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
REQ-031 fetch_cnt SHALL increment on each cycle with instr_valid and instr_ready high; stall_cnt SHALL increment on each cycle with instr_valid high and instr_ready low.
REQ-032 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-033 Without FETCH_CTRL_PERF_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Reset release, instr_ready=1, memory word n = n -> instr_pc 0,1,2,3 on consecutive cycles from the second cycle after release, with instr == instr_pc.
REQ-035 instr_ready=0 for 3 cycles while instr_pc=2 -> instr_valid, instr_pc=2 and instr stable throughout; im_addr=2; the next cycle after ready returns shows instr_pc=3.
REQ-036 redirect with redirect_addr=0x40 while pc=5 -> no instr_valid in the following cycle, then instr_pc 0x40, 0x41.
REQ-037 halt while instr_pc=7 and instr_ready=1 -> 7 is accepted, then im_en=0 and instr_valid=0; a later redirect to 0x10 with halt=0 -> fetch resumes at 0x10.
REQ-038 RESET_PC=32'hFFFFFFFF -> instr_pc FFFFFFFF followed by 0; rst_n pulsed low mid-run -> instr_valid drops to 0 immediately.
REQ-039 With FETCH_CTRL_PERF_EN: 10 accepts and 4 stall cycles -> fetch_cnt=10, stall_cnt=4.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer in front of a registered-read instruction memory.
// Latency: one cycle from issue (im_en/im_addr) to instr_valid; one instruction per cycle sustained.
// Backpressure: instr_ready low holds instr/instr_pc and re-reads the same word; redirect squashes it.
// Optional macro FETCH_CTRL_PERF_EN adds saturating fetch_cnt/stall_cnt outputs.
module fetch_ctrl #(
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [AW-1:0] ADDR_STEP = AW'(1)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] im_addr,
  output logic          im_en,
  input  logic [31:0]   im_instr,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_addr,
  input  logic          halt,
  output logic [31:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] req_pc;
  logic          req_v;
  logic          hold;

  // A presented instruction that is not taken keeps everything frozen.
  assign hold = req_v && !instr_ready;

  // The memory returns data one cycle after the address, so the data path is a plain wire.
  assign instr       = im_instr;
  assign instr_pc    = req_pc;
  assign instr_valid = req_v;

  // Memory request: re-read the held word on stall, else issue from pc; nothing on redirect or halt.
  always_comb begin
    im_en   = 1'b0;
    im_addr = pc;
    if (state == RUN && !redirect) begin
      if (hold) begin
        im_en   = 1'b1;
        im_addr = req_pc;
      end else if (!halt) begin
        im_en = 1'b1;
      end
    end
  end

  // Sequencer: state, next-issue pc and the single in-flight request slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      req_v  <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (redirect) begin
            // Redirect beats hold: the pending word is dropped even if not yet taken.
            pc    <= redirect_addr;
            req_v <= 1'b0;
            if (halt) state <= HALT;
          end else if (!hold) begin
            if (halt) begin
              // Any pending word was accepted this cycle, so the slot is empty now.
              req_v <= 1'b0;
              state <= HALT;
            end else begin
              req_pc <= pc;
              req_v  <= 1'b1;
              pc     <= pc + ADDR_STEP;
            end
          end
        end
        HALT: begin
          if (redirect) begin
            pc    <= redirect_addr;
            req_v <= 1'b0;
            if (!halt) state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  // Saturating counters of accepted instructions and of cycles a presented word was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (req_v && instr_ready && fetch_cnt != 32'hFFFF_FFFF)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (req_v && !instr_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a cycle model and literal spot checks.
// u0 uses default parameters; u1 starts at all-ones to exercise pc wrap.
// Memory models return word n = n, registered one cycle after the address.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr, im_instr, redirect_addr, instr, instr_pc;
  logic        im_en, redirect, halt, instr_valid, instr_ready;

  logic [31:0] im_addr1, im_instr1, instr1, instr_pc1;
  logic        im_en1, instr_valid1;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt, fetch_cnt1, stall_cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_en(im_en), .im_instr(im_instr),
    .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef FETCH_CTRL_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  fetch_ctrl #(.AW(32), .RESET_PC(32'hFFFF_FFFF)) u1 (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr1), .im_en(im_en1), .im_instr(im_instr1),
    .redirect(1'b0), .redirect_addr(32'h0), .halt(1'b0),
    .instr(instr1), .instr_pc(instr_pc1), .instr_valid(instr_valid1), .instr_ready(1'b1)
`ifdef FETCH_CTRL_PERF_EN
    , .fetch_cnt(fetch_cnt1), .stall_cnt(stall_cnt1)
`endif
  );

  // Instruction memories: word n holds n.
  always @(posedge clk) begin
    if (im_en)  im_instr  <= im_addr;
    if (im_en1) im_instr1 <= im_addr1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: 0 = waiting after reset, 1 = fetching, 2 = halted.
  int          m_mode = 0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_vpc  = 32'h0;
  bit          m_v    = 1'b0;
  logic [31:0] m_fc   = 32'h0;
  logic [31:0] m_sc   = 32'h0;

  // Compare process: check u0 against the model each cycle, then advance the model by one edge.
  always @(negedge clk) begin
    bit          e_en;
    logic [31:0] e_addr;
    #2;
    if (!rst_n) begin
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_im_en", 32'(im_en), 32'h0);
      m_mode = 0; m_pc = 32'h0; m_vpc = 32'h0; m_v = 1'b0; m_fc = 32'h0; m_sc = 32'h0;
    end else begin
      e_en = 1'b0;
      e_addr = m_pc;
      if (m_mode == 1 && !redirect) begin
        if (m_v && !instr_ready) begin
          e_en = 1'b1;
          e_addr = m_vpc;
        end else if (!halt) begin
          e_en = 1'b1;
        end
      end
      chk("mdl_instr_valid", 32'(instr_valid), 32'(m_v));
      chk("mdl_im_en", 32'(im_en), 32'(e_en));
      if (e_en) chk("mdl_im_addr", im_addr, e_addr);
      if (m_v) begin
        chk("mdl_instr_pc", instr_pc, m_vpc);
        chk("mdl_instr", instr, m_vpc);
      end
`ifdef FETCH_CTRL_PERF_EN
      chk("mdl_fetch_cnt", fetch_cnt, m_fc);
      chk("mdl_stall_cnt", stall_cnt, m_sc);
`endif
      if (m_v && instr_ready && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      if (m_v && !instr_ready && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (redirect) begin
            m_pc = redirect_addr;
            m_v = 1'b0;
            if (halt) m_mode = 2;
          end else if (m_v && !instr_ready) begin
            m_mode = 1;
          end else if (halt) begin
            m_v = 1'b0;
            m_mode = 2;
          end else begin
            m_vpc = m_pc;
            m_v = 1'b1;
            m_pc = m_pc + 32'd1;
          end
        end
        default: begin
          if (redirect) begin
            m_pc = redirect_addr;
            m_v = 1'b0;
            if (!halt) m_mode = 1;
          end
        end
      endcase
    end
  end

  // One cycle: drive inputs at the falling edge, return 3 time units later for spot checks.
  task automatic cyc(input bit rn, input bit rd, input logic [31:0] ra, input bit h, input bit rdy);
    @(negedge clk);
    rst_n = rn;
    redirect = rd;
    redirect_addr = ra;
    halt = h;
    instr_ready = rdy;
    #3;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_addr = 32'h0; halt = 1'b0; instr_ready = 1'b1;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_valid", 32'(instr_valid), 32'h0);
    chk("reset_im_en", 32'(im_en), 32'h0);

    // Release and stream 0..3.
    cyc(1, 0, 0, 0, 1);
    chk("idle_valid", 32'(instr_valid), 32'h0);
    chk("idle_im_en", 32'(im_en), 32'h0);
    cyc(1, 0, 0, 0, 1);
    chk("first_im_en", 32'(im_en), 32'h1);
    chk("first_im_addr", im_addr, 32'h0);
    cyc(1, 0, 0, 0, 1);
    chk("stream_pc0", instr_pc, 32'h0);
    chk("stream_v0", 32'(instr_valid), 32'h1);
    chk("wrap_pc_ones", instr_pc1, 32'hFFFF_FFFF);
    chk("wrap_instr_ones", instr1, 32'hFFFF_FFFF);
    cyc(1, 0, 0, 0, 1);
    chk("stream_pc1", instr_pc, 32'h1);
    chk("wrap_pc_zero", instr_pc1, 32'h0);
    chk("wrap_v_zero", 32'(instr_valid1), 32'h1);
    cyc(1, 0, 0, 0, 1);
    chk("stream_pc2", instr_pc, 32'h2);
    cyc(1, 0, 0, 0, 1);
    chk("stream_pc3", instr_pc, 32'h3);
    chk("stream_instr3", instr, 32'h3);

    // Redirect to 0x40 while pc=5 (instr_pc=4).
    cyc(1, 1, 32'h40, 0, 1);
    chk("redir_pc4", instr_pc, 32'h4);
    chk("redir_im_en", 32'(im_en), 32'h0);
    cyc(1, 0, 0, 0, 1);
    chk("redir_bubble", 32'(instr_valid), 32'h0);
    chk("redir_im_addr", im_addr, 32'h40);
    cyc(1, 0, 0, 0, 1);
    chk("redir_pc40", instr_pc, 32'h40);
    cyc(1, 0, 0, 0, 1);
    chk("redir_pc41", instr_pc, 32'h41);

    // Get to instr_pc=7, then halt as it is accepted.
    cyc(1, 1, 32'h7, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 1);
    chk("halt_pc7", instr_pc, 32'h7);
    chk("halt_no_issue", 32'(im_en), 32'h0);
    cyc(1, 0, 0, 1, 1);
    chk("halted_valid", 32'(instr_valid), 32'h0);
    chk("halted_im_en", 32'(im_en), 32'h0);
    cyc(1, 0, 0, 0, 1);
    chk("halted_stays", 32'(im_en), 32'h0);
    cyc(1, 1, 32'h10, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("resume_im_addr", im_addr, 32'h10);
    cyc(1, 0, 0, 0, 1);
    chk("resume_pc10", instr_pc, 32'h10);

    // Redirect+halt while a word is held, then redirects inside HALT.
    cyc(1, 1, 32'h20, 1, 0);
    chk("redir_over_hold", 32'(im_en), 32'h0);
    cyc(1, 1, 32'h30, 1, 1);
    chk("halt_redir_valid", 32'(instr_valid), 32'h0);
    cyc(1, 1, 32'h50, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("halt_exit_addr", im_addr, 32'h50);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("run_pc51", instr_pc, 32'h51);

    // Reset mid-run drops instr_valid immediately.
    cyc(0, 0, 0, 0, 1);
    chk("midrst_valid", 32'(instr_valid), 32'h0);
    cyc(0, 0, 0, 0, 1);

    // Second run: stalls at pc 2 and pc 3; 10 accepts and 4 stall cycles in total.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0);
      chk("stall_pc", instr_pc, 32'h2);
      chk("stall_instr", instr, 32'h2);
      chk("stall_valid", 32'(instr_valid), 32'h1);
      chk("stall_im_addr", im_addr, 32'h2);
    end
    cyc(1, 0, 0, 0, 1);
    chk("stall_release_pc", instr_pc, 32'h2);
    cyc(1, 0, 0, 0, 0);
    chk("after_stall_pc3", instr_pc, 32'h3);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("post_perf_pc", instr_pc, 32'hA);
`ifdef FETCH_CTRL_PERF_EN
    chk("perf_fetch", fetch_cnt, 32'd10);
    chk("perf_stall", stall_cnt, 32'd4);
`endif
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
